// File: rtl/ram_cmd_responder_pkg.sv
// ram_cmd_responder_pkg
//  Shared definitions for the CPU-to-RAM command interface. The operation
//  codes live here so the controller and this responder import one source.
//  - op_e          : command codes on the operation bus (IDLE/GET/SET/RESET)
//  - DEF_*         : default geometry and latency of the responder
package ram_cmd_responder_pkg;

    typedef enum logic [1:0] {
        OP_IDLE  = 2'd0,
        OP_GET   = 2'd1,
        OP_SET   = 2'd2,
        OP_RESET = 2'd3
    } op_e;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_ADDR_W   = 4;
    localparam int DEF_DEPTH    = 16;
    localparam int DEF_READ_LAT = 1;

endpackage

// File: rtl/ram_cmd_responder_regfile.sv
// ram_regfile
//  DEPTH x DATA_W register-file array. Asynchronously cleared to zero by
//  reset_n, one synchronous write port, one combinational read port.
//  Ports:
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low clear of every word
//   we       in   write enable
//   waddr    in   write address
//   wdata    in   write data
//   raddr    in   read address
//   rdata    out  word at raddr (combinational)
module ram_regfile #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    // Every address must map to a real word, so no range checks are needed.
    generate
        if (DEPTH != (1 << ADDR_W)) begin : g_bad_depth
            $error("ram_regfile: DEPTH must equal 2**ADDR_W");
        end
    endgenerate

    logic [DATA_W-1:0] mem_reg [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (we) begin
            mem_reg[waddr] <= wdata;
        end
    end

    assign rdata = mem_reg[raddr];

endmodule

// File: rtl/ram_cmd_responder.sv
// ram_cmd_responder
//  Responder end of the CPU-to-RAM command interface. Executes GET, SET and
//  RESET (clear all words) against a DEPTH x DATA_W register file and reports
//  completion with a level handshake on done.
//  Ports:
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   operation  in   command code (op_e)
//   address    in   word address, sampled when a command is accepted
//   data_in    in   SET data, sampled when a command is accepted
//   data_out   out  last word read; held until the next GET completes
//   done       out  command complete; held until operation leaves that code
//   busy       out  high from acceptance until done rises
module ram_cmd_responder
    import ram_cmd_responder_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int READ_LAT = DEF_READ_LAT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        operation,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              done,
    output logic              busy
);

    generate
        if (READ_LAT < 1) begin : g_bad_lat
            $error("ram_cmd_responder: READ_LAT must be at least 1");
        end
    endgenerate

    // The latency counter only ever counts up to READ_LAT-1.
    localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_CLEAR,
        S_DONE
    } state_e;

    state_e            state_reg;
    logic [1:0]        op_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] data_reg;
    logic [ADDR_W-1:0] clr_cnt_reg;
    logic [LAT_W-1:0]  lat_cnt_reg;
    logic [DATA_W-1:0] data_out_reg;
    logic              done_reg;
    logic              busy_reg;

    logic              lat_expired;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    assign lat_expired = (lat_cnt_reg == LAT_W'(READ_LAT - 1));

    // The clear sweep owns the write port while in S_CLEAR; otherwise the
    // only writer is a SET whose latency has elapsed.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addr_reg;
        mem_wdata = data_reg;
        if (state_reg == S_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_cnt_reg;
            mem_wdata = '0;
        end else if (state_reg == S_WRITE && lat_expired) begin
            mem_we = 1'b1;
        end
    end

    ram_regfile #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_regfile (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (mem_we),
        .waddr   (mem_waddr),
        .wdata   (mem_wdata),
        .raddr   (addr_reg),
        .rdata   (mem_rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= S_IDLE;
            op_reg       <= OP_IDLE;
            addr_reg     <= '0;
            data_reg     <= '0;
            clr_cnt_reg  <= '0;
            lat_cnt_reg  <= '0;
            data_out_reg <= '0;
            done_reg     <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (operation != OP_IDLE) begin
                        op_reg      <= operation;
                        addr_reg    <= address;
                        data_reg    <= data_in;
                        busy_reg    <= 1'b1;
                        lat_cnt_reg <= '0;
                        clr_cnt_reg <= '0;
                        case (operation)
                            OP_GET:  state_reg <= S_READ;
                            OP_SET:  state_reg <= S_WRITE;
                            default: state_reg <= S_CLEAR;
                        endcase
                    end
                end
                S_READ: begin
                    if (lat_expired) begin
                        data_out_reg <= mem_rdata;
                        done_reg     <= 1'b1;
                        busy_reg     <= 1'b0;
                        state_reg    <= S_DONE;
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg + 1'b1;
                    end
                end
                S_WRITE: begin
                    // The write itself happens through mem_we on this edge.
                    if (lat_expired) begin
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= S_DONE;
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg + 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (clr_cnt_reg == ADDR_W'(DEPTH - 1)) begin
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= S_DONE;
                    end else begin
                        clr_cnt_reg <= clr_cnt_reg + 1'b1;
                    end
                end
                S_DONE: begin
                    // Holding the same code keeps done high without re-running
                    // the command; any other code (IDLE or new) ends the cycle.
                    if (operation != op_reg) begin
                        done_reg  <= 1'b0;
                        state_reg <= S_IDLE;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign data_out = data_out_reg;
    assign done     = done_reg;
    assign busy     = busy_reg;

endmodule
